// File: rtl/axis_fcs_check.sv
// Ethernet FCS/length checker on an 8-bit AXI-Stream path; bad frames get tuser=1 on tlast.
// Define AXIS_FCS_STRIP_EN to remove the 4 FCS bytes from the output stream.
`timescale 1ns/1ps
module axis_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        axis_aclk,
    input  logic        axis_aresetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] good_cnt,
    output logic [31:0] bad_cnt
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] LEN_MIN     = 11'(MIN_LEN);
    localparam logic [10:0] LEN_MAX     = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT     = 11'(MAX_LEN + 1);
    localparam logic [31:0] CNT_MAX     = 32'hFFFFFFFF;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + 32'd1;
    endfunction

    logic [31:0] r_crc;
    logic [10:0] r_len;
    logic        r_err;
    logic [7:0]  r_m_tdata;
    logic        r_m_tuser;
    logic        r_m_tlast;
    logic        r_m_tvalid;
    logic [31:0] r_good_cnt;
    logic [31:0] r_bad_cnt;

    logic        w_accept;
    logic [31:0] w_crc_next;
    logic [10:0] w_len_next;
    logic        w_frame_bad;
    logic        w_out_done;
    logic        w_emit;
    logic [7:0]  w_emit_data;
    logic        w_emit_last;
    logic        w_emit_user;

    assign s_axis_tready = axis_aresetn & (~r_m_tvalid | m_axis_tready);
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_crc_next    = crc32_byte(r_crc, s_axis_tdata);
    assign w_len_next    = (r_len == LEN_SAT) ? LEN_SAT : r_len + 11'd1;
    assign w_out_done    = r_m_tvalid & m_axis_tready & r_m_tlast;

    // Verdict uses the state including the current (tlast) byte.
    assign w_frame_bad = r_err | s_axis_tuser | (w_crc_next != CRC_RESIDUE) |
                         (w_len_next < LEN_MIN) | (w_len_next > LEN_MAX);

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_crc <= CRC_INIT;
            r_len <= 11'd0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            if (s_axis_tlast) begin
                r_crc <= CRC_INIT;
                r_len <= 11'd0;
                r_err <= 1'b0;
            end else begin
                r_crc <= w_crc_next;
                r_len <= w_len_next;
                r_err <= r_err | s_axis_tuser;
            end
        end
    end

`ifdef AXIS_FCS_STRIP_EN
    logic [7:0] r_dl [4];
    logic [2:0] r_held;
    logic       w_full;

    assign w_full = (r_held == 3'd4);

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_held <= 3'd0;
        end else if (w_accept) begin
            if (s_axis_tlast) begin
                r_held <= 3'd0;
            end else if (!w_full) begin
                r_held <= r_held + 3'd1;
            end
        end
    end

    // Data-only shift register; occupancy is tracked by r_held.
    always_ff @(posedge axis_aclk) begin
        if (w_accept && !s_axis_tlast) begin
            r_dl[0] <= s_axis_tdata;
            r_dl[1] <= r_dl[0];
            r_dl[2] <= r_dl[1];
            r_dl[3] <= r_dl[2];
        end
    end

    // A frame of 4 bytes or fewer has no payload left once FCS is removed.
    always_comb begin
        w_emit      = w_accept & (w_full | s_axis_tlast);
        w_emit_data = w_full ? r_dl[3] : 8'h00;
        w_emit_last = s_axis_tlast;
        w_emit_user = s_axis_tlast & (w_frame_bad | ~w_full);
    end
`else
    always_comb begin
        w_emit      = w_accept;
        w_emit_data = s_axis_tdata;
        w_emit_last = s_axis_tlast;
        w_emit_user = s_axis_tlast & w_frame_bad;
    end
`endif

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_m_tdata  <= 8'h00;
            r_m_tuser  <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else if (w_emit) begin
            r_m_tdata  <= w_emit_data;
            r_m_tuser  <= w_emit_user;
            r_m_tlast  <= w_emit_last;
            r_m_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_good_cnt <= 32'd0;
            r_bad_cnt  <= 32'd0;
        end else if (w_out_done) begin
            if (r_m_tuser) begin
                r_bad_cnt <= sat_inc32(r_bad_cnt);
            end else begin
                r_good_cnt <= sat_inc32(r_good_cnt);
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tvalid = r_m_tvalid;
    assign good_cnt      = r_good_cnt;
    assign bad_cnt       = r_bad_cnt;

endmodule

// File: tb/tb_axis_fcs_check.sv
// Directed bench for axis_fcs_check; expectations adapt when AXIS_FCS_STRIP_EN is defined.
`timescale 1ns/1ps
module tb_axis_fcs_check;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;

    axis_fcs_check #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rstn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .good_cnt      (good_cnt),
        .bad_cnt       (bad_cnt)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;
    int   rcyc = 0;
    int   n_lasts = 0;
    bq_t  got_d;
    logic got_l[$];
    logic got_u[$];
    bq_t  exp_d;
    logic exp_l[$];
    logic exp_u[$];

    // Downstream ready: constant 1, or the repeating 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        rcyc = rcyc + 1;
        m_tready = (rdy_mode == 0) ? 1'b1 : ((rcyc % 4 == 0) || (rcyc % 4 == 3));
    end

    // Record every beat whose handshake completes on the following rising edge.
    always @(negedge clk) begin
        if (rstn && m_tvalid && m_tready) begin
            got_d.push_back(m_tdata);
            got_l.push_back(m_tlast);
            got_u.push_back(m_tuser);
            if (m_tlast) n_lasts = n_lasts + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Payload of npay bytes counting up from start, followed by a correct FCS.
    function automatic bq_t build(input int npay, input logic [7:0] start);
        bq_t q;
        logic [31:0] c;
        logic [31:0] fcs;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < npay; i++) begin
            q.push_back(8'(start + i));
            c = crc_byte(c, 8'(start + i));
        end
        fcs = ~c;
        q.push_back(fcs[7:0]);
        q.push_back(fcs[15:8]);
        q.push_back(fcs[23:16]);
        q.push_back(fcs[31:24]);
        return q;
    endfunction

    task automatic add_exp(input bq_t f, input logic user);
        int n;
        n = f.size();
`ifdef AXIS_FCS_STRIP_EN
        if (n <= 4) begin
            exp_d.push_back(8'h00);
            exp_l.push_back(1'b1);
            exp_u.push_back(1'b1);
        end else begin
            for (int i = 0; i < n - 4; i++) begin
                exp_d.push_back(f[i]);
                exp_l.push_back(i == n - 5);
                exp_u.push_back((i == n - 5) ? user : 1'b0);
            end
        end
`else
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(f[i]);
            exp_l.push_back(i == n - 1);
            exp_u.push_back((i == n - 1) ? user : 1'b0);
        end
`endif
    endtask

    // Send the first n bytes of f; tlast only on the real last byte.
    task automatic send(input bq_t f, input int n, input int err_idx);
        for (int i = 0; i < n; i++) begin
            int   g;
            logic acc;
            g = 0;
            acc = 1'b0;
            s_tvalid = 1'b1;
            s_tdata  = f[i];
            s_tlast  = (i == f.size() - 1);
            s_tuser  = (i == err_idx);
            while (!acc && g < 200) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk);
                #1;
                g++;
            end
            chk("input_accept", acc, 1'b1);
            if (!acc) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_lasts(input int target);
        int g;
        g = 0;
        while (n_lasts < target && g < 20000) begin
            @(posedge clk);
            g++;
        end
        chk("drain_tlast_count", n_lasts, target);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input int base);
        int bad;
        bad = 0;
        chk({tag, "_beats"}, got_d.size() - base, exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            if (base + i >= got_d.size()) bad++;
            else if (got_d[base+i] !== exp_d[i] || got_l[base+i] !== exp_l[i] ||
                     got_u[base+i] !== exp_u[i]) bad++;
        end
        chk({tag, "_beat_errors"}, bad, 0);
        exp_d.delete();
        exp_l.delete();
        exp_u.delete();
    endtask

    task automatic run_frame(input string tag, input bq_t f, input int err_idx, input logic user);
        int base;
        int lb;
        base = got_d.size();
        lb = n_lasts;
        add_exp(f, user);
        send(f, f.size(), err_idx);
        wait_lasts(lb + 1);
        check_stream(tag, base);
    endtask

    initial begin
        bq_t f, f2, fa, fb, f1, f3, frunt, fbig;
        int  base, lb;

        f     = build(60, 8'h00);
        f2    = f;
        f2[10] = f2[10] ^ 8'h01;
        frunt = build(36, 8'h00);
        fbig  = build(1526, 8'h00);
        fa    = build(60, 8'h40);
        fb    = build(100, 8'h80);
        f1    = '{8'h55};
        f3    = '{8'h01, 8'h02, 8'h03};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tdata", m_tdata, 8'h00);
        chk("rst_m_tlast", m_tlast, 1'b0);
        chk("rst_m_tuser", m_tuser, 1'b0);
        chk("rst_good_cnt", good_cnt, 32'd0);
        chk("rst_bad_cnt", bad_cnt, 32'd0);
        chk("rst_s_tready", s_tready, 1'b0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        run_frame("good64", f, -1, 1'b0);
        chk("good64_good_cnt", good_cnt, 32'd1);
        chk("good64_bad_cnt", bad_cnt, 32'd0);

        run_frame("crcerr", f2, -1, 1'b1);
        chk("crcerr_bad_cnt", bad_cnt, 32'd1);
        chk("crcerr_good_cnt", good_cnt, 32'd1);

        run_frame("runt40", frunt, -1, 1'b1);
        chk("runt40_bad_cnt", bad_cnt, 32'd2);
        run_frame("over1530", fbig, -1, 1'b1);
        chk("over1530_bad_cnt", bad_cnt, 32'd3);

        rdy_mode = 1;
        base = got_d.size();
        lb = n_lasts;
        add_exp(fa, 1'b0);
        add_exp(fb, 1'b0);
        send(fa, fa.size(), -1);
        send(fb, fb.size(), -1);
        wait_lasts(lb + 2);
        check_stream("b2b", base);
        chk("b2b_good_cnt", good_cnt, 32'd3);
        rdy_mode = 0;

        run_frame("rxer", f, 19, 1'b1);
        chk("rxer_bad_cnt", bad_cnt, 32'd4);

        run_frame("single", f1, -1, 1'b1);
        chk("single_bad_cnt", bad_cnt, 32'd5);

        send(f, 30, -1);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_s_tready", s_tready, 1'b0);
        chk("midrst_m_tvalid", m_tvalid, 1'b0);
        chk("midrst_good_cnt", good_cnt, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        lb = n_lasts;
        run_frame("after_rst", f, -1, 1'b0);
        chk("after_rst_one_tlast", n_lasts - lb, 1);
        chk("after_rst_good_cnt", good_cnt, 32'd1);
        chk("after_rst_bad_cnt", bad_cnt, 32'd0);

        run_frame("three_byte", f3, -1, 1'b1);
        chk("three_byte_bad_cnt", bad_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
